// File: rtl/mig_phrase_scheduler.sv
// Arbitrates one MIG UI port between the write-phrase and read-phrase streams,
// with per-side frame address counters and read-credit flow control. Optional stats: MIG_SCHED_STATS_EN.
module mig_phrase_scheduler #(
    parameter int unsigned FRAME_PHRASES = 38400,
    parameter int unsigned BURST         = 16,
    parameter int unsigned RD_CREDITS    = 8,
    parameter int unsigned ADDR_W        = 27
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              init_calib_complete,
    input  logic              wr_valid_in,
    output logic              wr_ready_out,
    input  logic [127:0]      wr_data_in,
    input  logic              wr_tuser_in,
    output logic              rd_valid_out,
    output logic [127:0]      rd_data_out,
    output logic              rd_tuser_out,
    input  logic              rd_credit_in,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [127:0]      app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic [127:0]      app_rd_data,
`ifdef MIG_SCHED_STATS_EN
    output logic [31:0]       wr_count_out,
    output logic [31:0]       rd_count_out,
    output logic [31:0]       stall_count_out,
`endif
    input  logic              app_rd_data_valid
);

    localparam int unsigned PH_W = $clog2(FRAME_PHRASES);
    localparam int unsigned BC_W = $clog2(BURST + 1);
    localparam int unsigned CR_W = $clog2(RD_CREDITS + 1);
    localparam logic [2:0]  CMD_WR = 3'b000;
    localparam logic [2:0]  CMD_RD = 3'b001;

    typedef enum logic [1:0] {S_CALIB, S_IDLE, S_WRITE, S_READ} state_t;

    state_t          state, state_nxt;
    logic [PH_W-1:0] wa, ra, rr;
    logic [BC_W-1:0] bcnt;
    logic [CR_W-1:0] credits;
    logic            last_rd;
    logic            wr_en_c, rd_en_c, wr_hs_c, rd_hs_c, burst_end_c, has_credit_c;
    logic [PH_W-1:0] wa_eff_c;

    function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] v);
        return (v == PH_W'(FRAME_PHRASES - 1)) ? '0 : v + PH_W'(1);
    endfunction

    // Command qualification; a tuser phrase realigns the write address to 0
    always_comb begin
        has_credit_c = (credits != '0);
        wr_en_c      = (state == S_WRITE) && wr_valid_in && app_wdf_rdy;
        rd_en_c      = (state == S_READ) && has_credit_c;
        wr_hs_c      = wr_en_c && app_rdy;
        rd_hs_c      = rd_en_c && app_rdy;
        burst_end_c  = (bcnt == BC_W'(BURST - 1));
        wa_eff_c     = wr_tuser_in ? '0 : wa;
    end

    always_comb begin
        app_en       = wr_en_c || rd_en_c;
        app_cmd      = (state == S_READ) ? CMD_RD : CMD_WR;
        wr_ready_out = wr_hs_c;
        app_wdf_data = wr_data_in;
        app_wdf_wren = wr_en_c;
        app_wdf_end  = wr_en_c;
        case (state)
            S_WRITE: app_addr = ADDR_W'({wa_eff_c, 3'b000});
            S_READ:  app_addr = ADDR_W'({ra, 3'b000});
            default: app_addr = '0;
        endcase
    end

    // Next state: a held command (app_en high, no app_rdy) never leaves its state
    always_comb begin
        state_nxt = state;
        case (state)
            S_CALIB: if (init_calib_complete) state_nxt = S_IDLE;
            S_IDLE: begin
                if (!init_calib_complete)            state_nxt = S_CALIB;
                else if (wr_valid_in && has_credit_c) state_nxt = last_rd ? S_WRITE : S_READ;
                else if (wr_valid_in)                 state_nxt = S_WRITE;
                else if (has_credit_c)                state_nxt = S_READ;
            end
            S_WRITE: if (!wr_en_c || (wr_hs_c && burst_end_c)) state_nxt = S_IDLE;
            S_READ:  if (!rd_en_c || (rd_hs_c && burst_end_c)) state_nxt = S_IDLE;
            default: state_nxt = S_CALIB;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= S_CALIB;
            last_rd <= 1'b1;
            bcnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                bcnt <= '0;
                if (state_nxt == S_WRITE)     last_rd <= 1'b0;
                else if (state_nxt == S_READ) last_rd <= 1'b1;
            end else if (wr_hs_c || rd_hs_c) begin
                bcnt <= bcnt + BC_W'(1);
            end
        end
    end

    // Frame address counters and read credits; simultaneous take and return cancel out
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wa      <= '0;
            ra      <= '0;
            credits <= CR_W'(RD_CREDITS);
        end else begin
            if (wr_hs_c) wa <= wr_tuser_in ? PH_W'(1) : ph_inc(wa);
            if (rd_hs_c) ra <= ph_inc(ra);
            if (rd_hs_c && !rd_credit_in)
                credits <= credits - CR_W'(1);
            else if (rd_credit_in && !rd_hs_c && credits != CR_W'(RD_CREDITS))
                credits <= credits + CR_W'(1);
        end
    end

    // Read return path, one register stage
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_valid_out <= 1'b0;
            rd_tuser_out <= 1'b0;
            rd_data_out  <= '0;
            rr           <= '0;
        end else begin
            rd_valid_out <= app_rd_data_valid;
            rd_tuser_out <= app_rd_data_valid && (rr == '0);
            if (app_rd_data_valid) begin
                rd_data_out <= app_rd_data;
                rr          <= ph_inc(rr);
            end
        end
    end

`ifdef MIG_SCHED_STATS_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_count_out    <= '0;
            rd_count_out    <= '0;
            stall_count_out <= '0;
        end else begin
            if (wr_hs_c)            wr_count_out    <= wr_count_out + 32'd1;
            if (rd_hs_c)            rd_count_out    <= rd_count_out + 32'd1;
            if (app_en && !app_rdy) stall_count_out <= stall_count_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mig_phrase_scheduler.sv
// Scoreboard bench for mig_phrase_scheduler: random phrase source, MIG model and
// downstream credit consumer feed expectation queues checked by a separate monitor.
module tb_mig_phrase_scheduler;

    localparam int unsigned FP     = 38400;
    localparam int unsigned ADDR_W = 27;
    localparam int unsigned RDC    = 8;

    typedef struct { logic [ADDR_W-1:0] addr; logic [127:0] data; } wexp_t;
    typedef struct { logic [127:0] data; int due; } mig_t;
    typedef struct { logic [127:0] data; logic tuser; int cyc; } rexp_t;

    logic clk_in = 1'b0;
    logic rst_n_in, init_calib_complete;
    logic wr_valid_in, wr_ready_out, wr_tuser_in;
    logic [127:0] wr_data_in, rd_data_out, app_wdf_data, app_rd_data;
    logic rd_valid_out, rd_tuser_out, rd_credit_in;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0] app_cmd;
    logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;

    mig_phrase_scheduler dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .init_calib_complete(init_calib_complete),
        .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out), .wr_data_in(wr_data_in),
        .wr_tuser_in(wr_tuser_in), .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
        .rd_tuser_out(rd_tuser_out), .rd_credit_in(rd_credit_in), .app_addr(app_addr),
        .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0, n_err = 0, cyc = 0;
    wexp_t wq[$];
    mig_t  migq[$];
    rexp_t rexp[$];
    int wr_hs = 0, rd_issued = 0, rd_released = 0, unconsumed = 0, ret_idx = 0, last_due = 0;
    int wcyc[64], rcyc[16];
    logic [ADDR_W-1:0] a_log[4];
    bit mon_en = 1, src_en = 1, cred_en = 0, rand_tuser = 0;
    int wr_prob = 100, cred_prob = 50, tuser_at = 100;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_wr(input int target, input int limit);
        int n = 0;
        while (wr_hs < target && n < limit) begin @(posedge clk_in); n++; end
        if (wr_hs < target) begin
            n_cmp++; n_err++;
            $display("FAIL wait_wr: got %0d writes, need %0d", wr_hs, target);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Phrase source with its own frame-position model for expected addresses
    logic src_acc, src_have;
    int fidx = 0, ph_idx = 0;
    initial begin
        wr_valid_in = 0; wr_data_in = '0; wr_tuser_in = 0; src_have = 0;
        forever begin
            @(negedge clk_in); src_acc = wr_ready_out;
            @(posedge clk_in); #1;
            if (src_acc || !src_have) begin
                wr_data_in  = {$urandom, $urandom, $urandom, $urandom};
                wr_tuser_in = (ph_idx == tuser_at) || (rand_tuser && $urandom_range(0, 199) == 0);
                if (wr_tuser_in) fidx = 0;
                wq.push_back('{addr: ADDR_W'(fidx * 8), data: wr_data_in});
                fidx = (fidx + 1) % FP; ph_idx++; src_have = 1;
                wr_valid_in = 0;
            end
            if (!src_en) wr_valid_in = 0;
            else if (!wr_valid_in) wr_valid_in = ($urandom_range(0, 99) < wr_prob);
        end
    end

    // MIG read-return model: in-order data a few cycles after each read command
    initial begin
        app_rd_data_valid = 0; app_rd_data = '0;
        forever begin
            mig_t m;
            @(posedge clk_in); #1;
            if (!rst_n_in) begin
                migq.delete(); app_rd_data_valid = 0;
            end else if (migq.size() > 0 && migq[0].due <= cyc) begin
                m = migq.pop_front();
                app_rd_data_valid = 1; app_rd_data = m.data;
                rexp.push_back('{data: m.data, tuser: (ret_idx % FP) == 0, cyc: cyc});
                ret_idx++;
            end else begin
                app_rd_data_valid = 0;
            end
        end
    end

    // Downstream FIFO consumer returning credits
    initial begin
        rd_credit_in = 0;
        forever begin
            @(posedge clk_in);
            if (rd_credit_in) rd_released++;
            #1;
            rd_credit_in = 0;
            if (cred_en && unconsumed > 0 && $urandom_range(0, 99) < cred_prob) begin
                rd_credit_in = 1; unconsumed--;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            wexp_t e; rexp_t r; int due;
            @(negedge clk_in);
            if (mon_en && rst_n_in) begin
                if (app_en && app_rdy && app_cmd == 3'b000) begin
                    if (wq.size() == 0) begin
                        n_cmp++; n_err++; $display("FAIL wr_extra: write with no phrase pending");
                    end else begin
                        e = wq.pop_front();
                        chk("wr_addr", 128'(app_addr), 128'(e.addr));
                        chk("wr_data", app_wdf_data, e.data);
                        chk("wr_strobes", 128'({app_wdf_wren, app_wdf_end, wr_ready_out}), 128'(3'b111));
                    end
                    if (wr_hs < 64) wcyc[wr_hs] = cyc;
                    if (wr_hs == 100)   a_log[0] = app_addr;
                    if (wr_hs == 101)   a_log[1] = app_addr;
                    if (wr_hs == 38499) a_log[2] = app_addr;
                    if (wr_hs == 38500) a_log[3] = app_addr;
                    wr_hs++;
                end else begin
                    chk("wr_ready_idle", 128'(wr_ready_out), 128'(0));
                end
                if (!app_en) chk("wdf_idle", 128'({app_wdf_wren, app_wdf_end}), 128'(0));
                if (app_en && app_rdy && app_cmd == 3'b001) begin
                    chk("rd_credit", 128'((rd_issued - rd_released) < RDC), 128'(1));
                    chk("rd_addr", 128'(app_addr), 128'((rd_issued % FP) * 8));
                    due = cyc + $urandom_range(2, 5);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    migq.push_back('{data: {$urandom, $urandom, $urandom, $urandom}, due: due});
                    if (rd_issued < 16) rcyc[rd_issued] = cyc;
                    rd_issued++;
                end
                if (rd_valid_out) begin
                    if (rexp.size() == 0) begin
                        n_cmp++; n_err++; $display("FAIL rd_extra: rd_valid_out with nothing returned");
                    end else begin
                        r = rexp.pop_front();
                        chk("rd_data", rd_data_out, r.data);
                        chk("rd_tuser", 128'(rd_tuser_out), 128'(r.tuser));
                        chk("rd_latency", 128'(cyc - r.cyc), 128'(1));
                        unconsumed++;
                    end
                end
            end
        end
    end

    initial begin
        int r0, nrd;
        logic [ADDR_W-1:0] first_ra;
        bit got;
        rst_n_in = 0; init_calib_complete = 0; app_rdy = 1; app_wdf_rdy = 1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_en", 128'({app_en, app_wdf_wren, app_wdf_end, wr_ready_out}), 128'(0));
        chk("rst_rd", 128'({rd_valid_out, rd_tuser_out}), 128'(0));
        chk("rst_addr", 128'(app_addr), 128'(0));
        chk("rst_rdata", rd_data_out, 128'(0));
        rst_n_in = 1;

        // Calibration held low with writes pending
        for (int i = 0; i < 50; i++) begin @(negedge clk_in); chk("calib_hold_en", 128'(app_en), 128'(0)); end
        @(posedge clk_in); #1; init_calib_complete = 1;
        @(negedge clk_in); chk("calib_c1_en", 128'(app_en), 128'(0));
        @(negedge clk_in); chk("calib_c2_en", 128'(app_en), 128'(0));
        @(negedge clk_in);
        chk("first_cmd", 128'({app_en, app_cmd}), 128'({1'b1, 3'b000}));
        chk("first_addr", 128'(app_addr), 128'(0));

        // Burst structure: 16 writes, IDLE, 8 reads until credits run out, then write bursts
        wait_wr(48, 300);
        chk("burst_w0_15", 128'(wcyc[15] - wcyc[0]), 128'(15));
        chk("switch_w_r", 128'(rcyc[0] - wcyc[15]), 128'(2));
        chk("burst_r0_7", 128'(rcyc[7] - rcyc[0]), 128'(7));
        chk("switch_r_w", 128'(wcyc[16] - rcyc[7]), 128'(3));
        chk("burst_w16_31", 128'(wcyc[31] - wcyc[16]), 128'(15));
        chk("burst_gap_wr", 128'(wcyc[32] - wcyc[31]), 128'(2));
        chk("rd_blocked", 128'(rd_issued), 128'(8));

        // app_rdy low for 5 cycles mid-burst: command held at its address
        wait_wr(52, 100);
        #1; app_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("stall_en", 128'(app_en), 128'(1));
            chk("stall_addr", 128'(app_addr), 128'(52 * 8));
        end
        @(posedge clk_in); #1; app_rdy = 1;

        // tuser realign at phrase 100, then the frame wrap
        wait_wr(38502, 45000);
        chk("tuser_addr", 128'(a_log[0]), 128'(0));
        chk("tuser_next", 128'(a_log[1]), 128'(8));
        chk("wrap_last", 128'(a_log[2]), 128'((FP - 1) * 8));
        chk("wrap_zero", 128'(a_log[3]), 128'(0));

        // Randomized mixed traffic with credit returns
        cred_en = 1; cred_prob = 50; wr_prob = 60; rand_tuser = 1;
        repeat (3000) begin
            @(posedge clk_in); #1;
            app_rdy     = ($urandom_range(0, 99) < 80);
            app_wdf_rdy = ($urandom_range(0, 99) < 85);
        end
        rand_tuser = 0; app_rdy = 0; app_wdf_rdy = 1; wr_prob = 0; cred_prob = 100;
        repeat (30) @(posedge clk_in);
        chk("drain_rexp", 128'(rexp.size()), 128'(0));
        chk("drain_mig", 128'(migq.size()), 128'(0));
        chk("drain_credits", 128'(rd_issued - rd_released), 128'(0));
        cred_en = 0; r0 = rd_issued;
        #1; app_rdy = 1;
        repeat (60) @(posedge clk_in);
        chk("credit_limit", 128'(rd_issued - r0), 128'(RDC));

        // Reset while a command is held
        wr_prob = 100; #1; app_rdy = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin @(negedge clk_in); got = app_en; end
        chk("held_before_rst", 128'(got), 128'(1));
        #1; mon_en = 0; rst_n_in = 0;
        #1;
        chk("rst_drop_en", 128'({app_en, app_wdf_wren, wr_ready_out}), 128'(0));
        repeat (2) @(negedge clk_in);
        rst_n_in = 1; app_rdy = 1;
        @(negedge clk_in); chk("post_rst_calib", 128'(app_en), 128'(0));
        @(negedge clk_in);
        chk("post_rst_cmd", 128'({app_en, app_cmd}), 128'({1'b1, 3'b000}));
        chk("post_rst_addr", 128'(app_addr), 128'(0));
        src_en = 0;
        nrd = 0; first_ra = '1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (app_en && app_rdy && app_cmd == 3'b001) begin
                if (nrd == 0) first_ra = app_addr;
                nrd++;
            end
        end
        chk("post_rst_credits", 128'(nrd), 128'(RDC));
        chk("post_rst_raddr", 128'(first_ra), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
